axis_fwd_tx_arbiter: RTL and testbench

Frame-atomic two-input AXI-Stream arbiter that merges host-originated TX traffic and the forward-path stream from the sync RX demultiplexer onto the single sync MAC TX interface. Sources are granted per frame with round-robin fairness and a configurable consecutive-frame burst limit. A registered skid buffer on the output provides full-throughput, registered outputs. Per-source frame counters are provided for status readback.

---
 rtl/axis_fwd_tx_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_axis_fwd_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fwd_tx_arbiter.sv
// Frame-atomic round-robin arbiter that merges host TX and forward streams onto one AXI-Stream
// output. It has a per-source burst limit, a registered skid-buffer output and per-source frame counters.
module axis_fwd_tx_arbiter #(
  parameter int AXIS_SYNC_DATA_WIDTH = 512,
  parameter int AXIS_SYNC_KEEP_WIDTH = AXIS_SYNC_DATA_WIDTH / 8,
  parameter int AXIS_SYNC_USER_WIDTH = 128,
  parameter int BURST_FRAMES         = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                            clk,
  input  logic                            aresetn,

  input  logic [AXIS_SYNC_DATA_WIDTH-1:0] s_axis_host_tdata,
  input  logic [AXIS_SYNC_KEEP_WIDTH-1:0] s_axis_host_tkeep,
  input  logic                            s_axis_host_tvalid,
  output logic                            s_axis_host_tready,
  input  logic                            s_axis_host_tlast,
  input  logic [AXIS_SYNC_USER_WIDTH-1:0] s_axis_host_tuser,

  input  logic [AXIS_SYNC_DATA_WIDTH-1:0] s_axis_fwd_tdata,
  input  logic [AXIS_SYNC_KEEP_WIDTH-1:0] s_axis_fwd_tkeep,
  input  logic                            s_axis_fwd_tvalid,
  output logic                            s_axis_fwd_tready,
  input  logic                            s_axis_fwd_tlast,
  input  logic [AXIS_SYNC_USER_WIDTH-1:0] s_axis_fwd_tuser,

  output logic [AXIS_SYNC_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_SYNC_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [AXIS_SYNC_USER_WIDTH-1:0] m_axis_tuser,

  input  logic                            cfg_fwd_enable,
  output logic [CNT_WIDTH-1:0]            stat_frames_host,
  output logic [CNT_WIDTH-1:0]            stat_frames_fwd,
  output logic [1:0]                      stat_grant
);

  localparam int BW = $clog2(BURST_FRAMES + 1);
  localparam int PW = AXIS_SYNC_DATA_WIDTH + AXIS_SYNC_KEEP_WIDTH + 1 + AXIS_SYNC_USER_WIDTH;
  localparam logic [BW:0] BURST_MAX = (BW + 1)'(BURST_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_HOST = 2'd1,
    ST_GNT_FWD  = 2'd2
  } state_t;

  state_t         state_q, state_d, other_st;
  logic           last_src_q, last_src_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [BW:0]    cnt_inc;
  logic           req_host, req_fwd, req_self, req_other;
  logic           frame_end;

  logic           in_valid, in_last;
  logic [PW-1:0]  in_pay;

  logic           int_ready_q, int_ready_early;
  logic           m_valid_q, m_valid_d;
  logic           temp_valid_q, temp_valid_d;
  logic [PW-1:0]  m_pay_q, temp_pay_q;
  logic           store_out, store_temp, temp_to_out;

  logic [CNT_WIDTH-1:0] host_cnt_q, fwd_cnt_q;

  // Granted source feeds the skid buffer; the other source sees tready low.
  always_comb begin
    in_valid = 1'b0;
    in_last  = s_axis_host_tlast;
    in_pay   = {s_axis_host_tdata, s_axis_host_tkeep, s_axis_host_tlast, s_axis_host_tuser};
    if (state_q == ST_GNT_FWD) begin
      in_valid = s_axis_fwd_tvalid;
      in_last  = s_axis_fwd_tlast;
      in_pay   = {s_axis_fwd_tdata, s_axis_fwd_tkeep, s_axis_fwd_tlast, s_axis_fwd_tuser};
    end else if (state_q == ST_GNT_HOST) begin
      in_valid = s_axis_host_tvalid;
    end
  end

  assign s_axis_host_tready = int_ready_q && (state_q == ST_GNT_HOST);
  assign s_axis_fwd_tready  = int_ready_q && (state_q == ST_GNT_FWD);

  assign req_host  = s_axis_host_tvalid;
  assign req_fwd   = s_axis_fwd_tvalid && cfg_fwd_enable;
  assign frame_end = in_valid && int_ready_q && in_last;
  assign cnt_inc   = {1'b0, burst_cnt_q} + (BW + 1)'(1);

  // Arbitration happens combinationally on the granted tlast handshake, so frames go back-to-back.
  always_comb begin
    state_d     = state_q;
    last_src_d  = last_src_q;
    burst_cnt_d = burst_cnt_q;
    req_self    = (state_q == ST_GNT_FWD) ? req_fwd  : req_host;
    req_other   = (state_q == ST_GNT_FWD) ? req_host : req_fwd;
    other_st    = (state_q == ST_GNT_FWD) ? ST_GNT_HOST : ST_GNT_FWD;
    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (req_host && req_fwd) begin
          state_d = last_src_q ? ST_GNT_HOST : ST_GNT_FWD;
        end else if (req_host) begin
          state_d = ST_GNT_HOST;
        end else if (req_fwd) begin
          state_d = ST_GNT_FWD;
        end
      end
      ST_GNT_HOST, ST_GNT_FWD: begin
        if (frame_end) begin
          last_src_d = (state_q == ST_GNT_FWD);
          if (req_other && (cnt_inc >= BURST_MAX)) begin
            state_d     = other_st;
            burst_cnt_d = '0;
          end else if (req_self) begin
            burst_cnt_d = (cnt_inc >= BURST_MAX) ? BURST_MAX[BW-1:0] : cnt_inc[BW-1:0];
          end else if (req_other) begin
            state_d     = other_st;
            burst_cnt_d = '0;
          end else begin
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Skid buffer: input readiness is registered, so a stalled beat lands in the temp register.
  assign int_ready_early = m_axis_tready || (!temp_valid_q && !m_valid_q);

  always_comb begin
    m_valid_d    = m_valid_q;
    temp_valid_d = temp_valid_q;
    store_out    = 1'b0;
    store_temp   = 1'b0;
    temp_to_out  = 1'b0;
    if (int_ready_q) begin
      if (m_axis_tready || !m_valid_q) begin
        m_valid_d = in_valid;
        store_out = 1'b1;
      end else begin
        temp_valid_d = in_valid;
        store_temp   = 1'b1;
      end
    end else if (m_axis_tready) begin
      m_valid_d    = temp_valid_q;
      temp_valid_d = 1'b0;
      temp_to_out  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      last_src_q   <= 1'b1;
      burst_cnt_q  <= '0;
      int_ready_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      temp_valid_q <= 1'b0;
      m_pay_q      <= '0;
      temp_pay_q   <= '0;
      host_cnt_q   <= '0;
      fwd_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_src_q   <= last_src_d;
      burst_cnt_q  <= burst_cnt_d;
      int_ready_q  <= int_ready_early;
      m_valid_q    <= m_valid_d;
      temp_valid_q <= temp_valid_d;
      if (store_out) begin
        m_pay_q <= in_pay;
      end else if (temp_to_out) begin
        m_pay_q <= temp_pay_q;
      end
      if (store_temp) begin
        temp_pay_q <= in_pay;
      end
      if (s_axis_host_tvalid && s_axis_host_tready && s_axis_host_tlast) begin
        host_cnt_q <= host_cnt_q + CNT_WIDTH'(1);
      end
      if (s_axis_fwd_tvalid && s_axis_fwd_tready && s_axis_fwd_tlast) begin
        fwd_cnt_q <= fwd_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = m_pay_q;
  assign m_axis_tvalid    = m_valid_q;
  assign stat_frames_host = host_cnt_q;
  assign stat_frames_fwd  = fwd_cnt_q;

  always_comb begin
    case (state_q)
      ST_GNT_HOST: stat_grant = 2'b01;
      ST_GNT_FWD:  stat_grant = 2'b10;
      default:     stat_grant = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_axis_fwd_tx_arbiter.sv
// Randomised bench for axis_fwd_tx_arbiter: a queue-based skid model plus frame-level arbitration
// rules predict grant, readies, output beats and counters every cycle.
module tb_axis_fwd_tx_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 16;
  localparam int BF = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic aresetn = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] h_tdata, f_tdata, m_tdata;
  logic [KW-1:0] h_tkeep, f_tkeep, m_tkeep;
  logic [UW-1:0] h_tuser, f_tuser, m_tuser;
  logic h_tvalid, h_tready, h_tlast;
  logic f_tvalid, f_tready, f_tlast;
  logic m_tvalid, m_tready, m_tlast;
  logic cfg_fwd_enable;
  logic [CW-1:0] stat_frames_host, stat_frames_fwd;
  logic [1:0] stat_grant;

  axis_fwd_tx_arbiter #(
    .AXIS_SYNC_DATA_WIDTH(DW),
    .AXIS_SYNC_KEEP_WIDTH(KW),
    .AXIS_SYNC_USER_WIDTH(UW),
    .BURST_FRAMES(BF),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_host_tdata(h_tdata), .s_axis_host_tkeep(h_tkeep), .s_axis_host_tvalid(h_tvalid),
    .s_axis_host_tready(h_tready), .s_axis_host_tlast(h_tlast), .s_axis_host_tuser(h_tuser),
    .s_axis_fwd_tdata(f_tdata), .s_axis_fwd_tkeep(f_tkeep), .s_axis_fwd_tvalid(f_tvalid),
    .s_axis_fwd_tready(f_tready), .s_axis_fwd_tlast(f_tlast), .s_axis_fwd_tuser(f_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .cfg_fwd_enable(cfg_fwd_enable),
    .stat_frames_host(stat_frames_host), .stat_frames_fwd(stat_frames_fwd),
    .stat_grant(stat_grant)
  );

  typedef struct {
    logic          src;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // Reference model: beats accepted but not yet delivered, current owner, fairness state.
  beat_t q[$];
  int    mgrant;   // 0 none, 1 host, 2 fwd
  int    mlast;
  int    mburst;
  bit    mrdy;
  int    mcnt_h, mcnt_f;

  int          cyc, out_beats, out_frames, first_out_cyc, last_out_cyc;
  logic [63:0] frame_src;
  logic        cur_out_src;
  bit          out_mid, fwd_rdy_seen;

  // Stimulus state per source (0 host, 1 fwd).
  int    frames_left[2], len_cfg[2], gap_pct[2], beat_idx[2], cur_len[2], frames_done[2];
  bit    vld[2], hs[2];
  beat_t cur[2];
  int    rdy_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mgrant = 0; mlast = 1; mburst = 0; mrdy = 1'b0; mcnt_h = 0; mcnt_f = 0;
    out_beats = 0; out_frames = 0; first_out_cyc = -1; last_out_cyc = -1;
    frame_src = '0; out_mid = 1'b0; cur_out_src = 1'b0; cyc = 0;
  endtask

  task automatic sample();
    logic [1:0] expg;
    bit rdy_next, req_h, req_f, rs, ro;
    int s, n;
    beat_t b;
    if (!aresetn) begin
      hs[0] = 1'b0; hs[1] = 1'b0;
      return;
    end
    cyc++;
    expg = (mgrant == 1) ? 2'b01 : (mgrant == 2) ? 2'b10 : 2'b00;
    chk("grant", stat_grant, expg);
    chk("host_tready", h_tready, (mgrant == 1) && mrdy);
    chk("fwd_tready", f_tready, (mgrant == 2) && mrdy);
    chk("m_tvalid", m_tvalid, q.size() != 0);
    if (m_tvalid && q.size() != 0) begin
      chk("m_tdata", m_tdata, q[0].data);
      chk("m_tkeep", m_tkeep, q[0].keep);
      chk("m_tlast", m_tlast, q[0].last);
      chk("m_tuser", m_tuser, q[0].user);
    end
    chk("cnt_host", stat_frames_host, mcnt_h % (1 << CW));
    chk("cnt_fwd", stat_frames_fwd, mcnt_f % (1 << CW));
    if (f_tready) fwd_rdy_seen = 1'b1;

    hs[0] = h_tvalid && h_tready;
    hs[1] = f_tvalid && f_tready;
    rdy_next = m_tready || (q.size() == 0);
    if (m_tvalid && m_tready && q.size() != 0) begin
      b = q.pop_front();
      out_beats++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      if (out_mid) chk("interleave", b.src, cur_out_src);
      cur_out_src = b.src;
      out_mid = !b.last;
      if (b.last) begin
        if (out_frames < 64) frame_src[out_frames] = b.src;
        out_frames++;
      end
    end
    if (hs[0]) q.push_back('{1'b0, h_tdata, h_tkeep, h_tlast, h_tuser});
    if (hs[1]) q.push_back('{1'b1, f_tdata, f_tkeep, f_tlast, f_tuser});

    req_h = h_tvalid;
    req_f = f_tvalid && cfg_fwd_enable;
    if (mgrant == 0) begin
      mburst = 0;
      if (req_h && req_f) mgrant = (mlast == 1) ? 1 : 2;
      else if (req_h)     mgrant = 1;
      else if (req_f)     mgrant = 2;
    end else begin
      s  = mgrant - 1;
      rs = (s == 0) ? req_h : req_f;
      ro = (s == 0) ? req_f : req_h;
      if (hs[s] && ((s == 0) ? h_tlast : f_tlast)) begin
        n = mburst + 1;
        mlast = s;
        if (ro && n >= BF) begin mgrant = 3 - mgrant; mburst = 0; end
        else if (rs)       begin mburst = (n > BF) ? BF : n; end
        else if (ro)       begin mgrant = 3 - mgrant; mburst = 0; end
        else               begin mgrant = 0; mburst = 0; end
      end
    end
    if (hs[0] && h_tlast) mcnt_h++;
    if (hs[1] && f_tlast) mcnt_f++;
    mrdy = rdy_next;
  endtask

  task automatic apply_inputs();
    h_tvalid = vld[0]; h_tdata = cur[0].data; h_tkeep = cur[0].keep;
    h_tlast = cur[0].last; h_tuser = cur[0].user;
    f_tvalid = vld[1]; f_tdata = cur[1].data; f_tkeep = cur[1].keep;
    f_tlast = cur[1].last; f_tuser = cur[1].user;
  endtask

  task automatic drive();
    m_tready = (rdy_mode != 0) ? 1'($urandom % 2) : 1'b1;
    for (int s = 0; s < 2; s++) begin
      if (vld[s] && hs[s]) begin
        if (cur[s].last) begin beat_idx[s] = 0; frames_done[s]++; end
        else beat_idx[s]++;
        vld[s] = 1'b0;
      end
      if (!vld[s] && (beat_idx[s] != 0 || frames_left[s] > 0) &&
          $urandom_range(99) >= gap_pct[s]) begin
        if (beat_idx[s] == 0) begin
          frames_left[s]--;
          cur_len[s] = (len_cfg[s] != 0) ? len_cfg[s] : int'($urandom_range(1, 5));
        end
        cur[s].src  = 1'(s);
        cur[s].data = {$urandom, $urandom};
        cur[s].keep = KW'($urandom);
        cur[s].user = UW'($urandom);
        cur[s].last = (beat_idx[s] == cur_len[s] - 1);
        vld[s] = 1'b1;
      end
      hs[s] = 1'b0;
    end
    apply_inputs();
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_host_tready", h_tready, 0);
    chk("rst_fwd_tready", f_tready, 0);
    chk("rst_grant", stat_grant, 0);
    chk("rst_cnt_host", stat_frames_host, 0);
    chk("rst_cnt_fwd", stat_frames_fwd, 0);
    model_reset();
    for (int s = 0; s < 2; s++) begin
      vld[s] = 1'b0; hs[s] = 1'b0; beat_idx[s] = 0; frames_left[s] = 0;
      frames_done[s] = 0; cur_len[s] = 1; len_cfg[s] = 0; gap_pct[s] = 0;
      cur[s] = '{1'(s), '0, '0, 1'b0, '0};
    end
    rdy_mode = 0;
    m_tready = 1'b1;
    apply_inputs();
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  function automatic bit all_idle();
    return frames_left[0] <= 0 && frames_left[1] <= 0 && beat_idx[0] == 0 && beat_idx[1] == 0 &&
           !vld[0] && !vld[1] && q.size() == 0;
  endfunction

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    while (!all_idle() && n < budget) begin step(); n++; end
    if (!all_idle()) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", name, budget);
    end
    repeat (3) step();
  endtask

  task automatic wait_fwd_beat(input int frames, input int idx, input string name);
    int n = 0;
    while (!(frames_done[1] == frames && beat_idx[1] == idx) && n < 300) begin step(); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=not_reached required=fwd_frame_%0d_beat_%0d", name, frames, idx);
    end
  endtask

  initial begin
    int n;
    cfg_fwd_enable = 1'b1;
    m_tready = 1'b1;
    model_reset();
    do_reset();

    // Single source: 3 host frames of 4 beats, no bubbles.
    len_cfg[0] = 4; frames_left[0] = 3;
    run_until_idle(200, "single");
    chk("single_host_frames", stat_frames_host, 3);
    chk("single_beats", out_beats, 12);
    chk("single_span", last_out_cyc - first_out_cyc, 11);

    // Contention: both continuously valid, 2-beat frames; 16 frames each wraps the 4-bit counters.
    do_reset();
    len_cfg[0] = 2; len_cfg[1] = 2; frames_left[0] = 16; frames_left[1] = 16;
    run_until_idle(400, "contention");
    chk("contention_frames", out_frames, 32);
    chk("contention_order_lo", frame_src[15:0], 16'hF0F0);
    chk("contention_order_hi", frame_src[31:16], 16'hF0F0);
    chk("contention_wrap_host", stat_frames_host, 0);
    chk("contention_wrap_fwd", stat_frames_fwd, 0);

    // Burst continuation: host arrives during fwd frame 5, after fwd already saturated.
    do_reset();
    len_cfg[0] = 2; len_cfg[1] = 3; frames_left[1] = 6;
    wait_fwd_beat(4, 1, "burst");
    frames_left[0] = 4;
    run_until_idle(300, "burst");
    chk("burst_frames", out_frames, 10);
    chk("burst_order", frame_src[9:0], 10'h21F);

    // Enable gating.
    do_reset();
    cfg_fwd_enable = 1'b0;
    len_cfg[1] = 3; frames_left[1] = 2;
    fwd_rdy_seen = 1'b0;
    repeat (20) step();
    chk("gate_fwd_ready", fwd_rdy_seen, 0);
    chk("gate_fwd_cnt", stat_frames_fwd, 0);
    chk("gate_grant", stat_grant, 2'b00);
    cfg_fwd_enable = 1'b1;
    wait_fwd_beat(0, 1, "gate");
    cfg_fwd_enable = 1'b0;
    repeat (30) step();
    chk("gate_fwd_cnt_after", stat_frames_fwd, 1);
    chk("gate_out_frames", out_frames, 1);
    chk("gate_grant_after", stat_grant, 2'b00);
    cfg_fwd_enable = 1'b1;

    // Random backpressure with both sources active, random lengths and gaps.
    do_reset();
    rdy_mode = 1;
    gap_pct[0] = 30; gap_pct[1] = 30;
    frames_left[0] = 100000; frames_left[1] = 100000;
    repeat (3000) step();
    chk("random_progress", out_frames > 100, 1);

    // Async reset mid-frame, then one intact frame.
    n = 0;
    while (!(m_tvalid && !m_tlast) && n < 200) begin step(); n++; end
    chk("midframe_found", m_tvalid && !m_tlast, 1);
    do_reset();
    len_cfg[0] = 4; frames_left[0] = 1;
    run_until_idle(100, "post_reset");
    chk("post_reset_host", stat_frames_host, 1);
    chk("post_reset_fwd", stat_frames_fwd, 0);
    chk("post_reset_beats", out_beats, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
